// File: rtl/panel_ctrl.sv
// rtl/panel_ctrl.sv - front-panel button conditioning and user state machine for the washer sequencer
module panel_ctrl #(
  parameter int DEB_CYC   = 2000000,
  parameter int BLINK_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_power,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       wash_done,
  output logic       on,
  output logic [1:0] mode,
  output logic       m_pos,
  output logic       wash_rst_n,
  output logic [3:0] mode_light,
  output logic       done_light
);

  localparam int DW         = $clog2(DEB_CYC + 1);
  localparam int BW         = $clog2(BLINK_CYC + 1);
  localparam int BLINK_LAST = BLINK_CYC - 1;
  localparam logic [DW-1:0] DEB_MAX   = DEB_CYC[DW-1:0];
  localparam logic [BW-1:0] BLINK_MAX = BLINK_LAST[BW-1:0];

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_PAUSE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Button index: 0 power, 1 mode, 2 start.
  logic [2:0]    w_raw;
  logic [2:0]    r_s1;
  logic [2:0]    r_s2;
  logic [2:0]    r_deb;
  logic [2:0]    r_armed;
  logic [2:0]    r_press;
  logic [1:0]    r_settle;
  logic [DW-1:0] r_cnt [3];

  logic [2:0]    r_state;
  logic [1:0]    r_mode;
  logic          r_on;
  logic          r_m_pos;
  logic          r_wash_rst_n;
  logic [3:0]    r_mode_light;
  logic          r_done_light;
  logic [BW-1:0] r_blink_cnt;

  logic          w_pwr;
  logic          w_start;
  logic          w_modep;
  logic [2:0]    w_next;
  logic [1:0]    w_mode_next;

  assign w_raw = {btn_start, btn_mode, btn_power};

  // A button only becomes armed once it has been seen released after reset,
  // so a button held through reset cannot produce a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_deb    <= '0;
      r_armed  <= '0;
      r_press  <= '0;
      r_settle <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1     <= w_raw;
      r_s2     <= r_s1;
      r_settle <= {r_settle[0], 1'b1};
      for (int i = 0; i < 3; i++) begin
        r_press[i] <= 1'b0;
        if (r_settle[1] && !r_s2[i] && !r_deb[i]) r_armed[i] <= 1'b1;
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_MAX) begin
          r_deb[i]   <= r_s2[i];
          r_cnt[i]   <= '0;
          r_press[i] <= r_s2[i] & r_armed[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pwr       = r_press[0];
    w_start     = r_press[2] & ~r_press[0];
    w_modep     = r_press[1] & ~r_press[0] & ~r_press[2];
    w_next      = r_state;
    w_mode_next = r_mode;
    case (r_state)
      S_OFF: begin
        if (w_pwr) w_next = S_SELECT;
      end
      S_SELECT: begin
        if (w_pwr)        w_next = S_OFF;
        else if (w_start) w_next = S_RUN;
        else if (w_modep) w_mode_next = r_mode + 2'd1;
      end
      S_RUN: begin
        if (w_pwr)          w_next = S_OFF;
        else if (wash_done) w_next = S_DONE;
        else if (w_start)   w_next = S_PAUSE;
      end
      S_PAUSE: begin
        if (w_pwr)        w_next = S_OFF;
        else if (w_start) w_next = S_RUN;
      end
      S_DONE: begin
        if (w_pwr) w_next = S_OFF;
      end
      default: w_next = S_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_OFF;
      r_mode       <= 2'b01;
      r_on         <= 1'b0;
      r_m_pos      <= 1'b0;
      r_wash_rst_n <= 1'b0;
      r_mode_light <= 4'b0000;
      r_done_light <= 1'b0;
      r_blink_cnt  <= '0;
    end else begin
      r_state      <= w_next;
      r_mode       <= w_mode_next;
      r_on         <= (w_next == S_SELECT) || (w_next == S_RUN) || (w_next == S_DONE);
      r_m_pos      <= (w_next == S_RUN) || (w_next == S_PAUSE) || (w_next == S_DONE);
      r_wash_rst_n <= (w_next != S_OFF);
      r_mode_light <= (w_next == S_OFF) ? 4'b0000 : (4'b0001 << w_mode_next);
      if (w_next == S_DONE) begin
        if (r_state != S_DONE) begin
          r_done_light <= 1'b1;
          r_blink_cnt  <= '0;
        end else if (r_blink_cnt == BLINK_MAX) begin
          r_done_light <= ~r_done_light;
          r_blink_cnt  <= '0;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end else begin
        r_done_light <= 1'b0;
        r_blink_cnt  <= '0;
      end
    end
  end

  assign on         = r_on;
  assign mode       = r_mode;
  assign m_pos      = r_m_pos;
  assign wash_rst_n = r_wash_rst_n;
  assign mode_light = r_mode_light;
  assign done_light = r_done_light;

endmodule

// File: tb/tb_panel_ctrl.sv
// tb/tb_panel_ctrl.sv - directed self-checking bench for panel_ctrl
module tb_panel_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_power;
  logic       btn_mode;
  logic       btn_start;
  logic       wash_done;
  logic       on;
  logic [1:0] mode;
  logic       m_pos;
  logic       wash_rst_n;
  logic [3:0] mode_light;
  logic       done_light;

  int n_checks = 0;
  int n_errors = 0;

  localparam int B_POWER = 0;
  localparam int B_MODE  = 1;
  localparam int B_START = 2;

  panel_ctrl #(.DEB_CYC(4), .BLINK_CYC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_power  (btn_power),
    .btn_mode   (btn_mode),
    .btn_start  (btn_start),
    .wash_done  (wash_done),
    .on         (on),
    .mode       (mode),
    .m_pos      (m_pos),
    .wash_rst_n (wash_rst_n),
    .mode_light (mode_light),
    .done_light (done_light)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic e_on, input logic e_mpos,
                             input logic e_wrn, input logic [1:0] e_mode,
                             input logic [3:0] e_ml, input logic e_dl);
    check({tag, ".on"},         32'(on),         32'(e_on));
    check({tag, ".m_pos"},      32'(m_pos),      32'(e_mpos));
    check({tag, ".wash_rst_n"}, 32'(wash_rst_n), 32'(e_wrn));
    check({tag, ".mode"},       32'(mode),       32'(e_mode));
    check({tag, ".mode_light"}, 32'(mode_light), 32'(e_ml));
    check({tag, ".done_light"}, 32'(done_light), 32'(e_dl));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_POWER: btn_power = v;
      B_MODE:  btn_mode  = v;
      default: btn_start = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    step(10);
    set_btn(b, 1'b0);
    step(10);
  endtask

  initial begin
    rst       = 1'b0;
    btn_power = 1'b0;
    btn_mode  = 1'b0;
    btn_start = 1'b0;
    wash_done = 1'b0;
    step(3);
    expect_outs("reset", 0, 0, 0, 2'b01, 4'b0000, 0);
    #2 rst = 1'b1;
    step(5);

    // Press pulse appears after edge 7 and is acted on at edge 8.
    btn_power = 1'b1;
    step(7);
    check("pwr_latency_e7.on", 32'(on), 32'd0);
    step(1);
    expect_outs("select", 1, 0, 1, 2'b01, 4'b0010, 0);
    step(2);
    btn_power = 1'b0;
    step(10);

    btn_mode = 1'b1;
    step(2);
    btn_mode = 1'b0;
    step(10);
    check("mode_glitch", 32'(mode), 32'd1);

    press(B_MODE);
    check("mode_p1", 32'(mode), 32'd2);
    check("mode_p1.light", 32'(mode_light), 32'b0100);
    press(B_MODE);
    check("mode_p2", 32'(mode), 32'd3);
    check("mode_p2.light", 32'(mode_light), 32'b1000);
    press(B_MODE);
    expect_outs("mode_wrap", 1, 0, 1, 2'b00, 4'b0001, 0);

    press(B_START);
    expect_outs("run", 1, 1, 1, 2'b00, 4'b0001, 0);
    press(B_START);
    expect_outs("pause", 0, 1, 1, 2'b00, 4'b0001, 0);
    press(B_START);
    expect_outs("resume", 1, 1, 1, 2'b00, 4'b0001, 0);
    press(B_MODE);
    expect_outs("run_mode_frozen", 1, 1, 1, 2'b00, 4'b0001, 0);

    // wash_done coincides with the start pulse cycle: completion must win.
    btn_start = 1'b1;
    step(7);
    wash_done = 1'b1;
    step(1);
    expect_outs("done_entry", 1, 1, 1, 2'b00, 4'b0001, 1);
    btn_start = 1'b0;
    step(7);
    check("blink_hi_last", 32'(done_light), 32'd1);
    step(1);
    check("blink_lo_first", 32'(done_light), 32'd0);
    step(7);
    check("blink_lo_last", 32'(done_light), 32'd0);
    step(1);
    check("blink_hi_again", 32'(done_light), 32'd1);
    step(10);

    press(B_POWER);
    expect_outs("off", 0, 0, 0, 2'b00, 4'b0000, 0);
    wash_done = 1'b0;
    press(B_POWER);
    expect_outs("reselect", 1, 0, 1, 2'b00, 4'b0001, 0);
    press(B_START);
    expect_outs("run2", 1, 1, 1, 2'b00, 4'b0001, 0);

    // Async reset between edges while power is held through it.
    btn_power = 1'b1;
    step(2);
    #2 rst = 1'b0;
    #1 expect_outs("async_rst", 0, 0, 0, 2'b01, 4'b0000, 0);
    #9 rst = 1'b1;
    step(20);
    expect_outs("held_no_press", 0, 0, 0, 2'b01, 4'b0000, 0);
    btn_power = 1'b0;
    step(10);
    press(B_POWER);
    expect_outs("after_rst", 1, 0, 1, 2'b01, 4'b0010, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
